nes_joypad: RTL
===============

// Module: nes_joypad
// PURPOSE
//  Responder side of the controller serial port: models two standard NES pads (4021-style 8-bit
//  parallel-in/serial-out registers) behind the $4016/$4017 strobe/read/data handshake driven by
//  the CPU/APU block. Raw board buttons are synchronised, debounced and optionally filtered for
//  opposing directions, latched on strobe, then shifted out one bit per read pulse.
// PARAMETERS
//  DEBOUNCE_CYCLES  50000  consecutive stable clk cycles before a button change is accepted (>=1)
//  BLOCK_OPPOSING   1      1: Up+Down (or Left+Right) both pressed -> both reported released
// PORTS
//  clk       in   1  system clock
//  rst       in   1  synchronous reset, active-high
//  strobe_i  in   1  latch control, driven from CPU $4016 write bit0; high = continuous reload
//  rd_i      in   2  one-cycle read pulses; bit0 = $4016 read (pad 0), bit1 = $4017 read (pad 1)
//  data_o    out  2  serial data; bit n = current bit of pad n shift register
//  btn0_i    in   8  pad 0 raw buttons, active-high, asynchronous
//  btn1_i    in   8  pad 1 raw buttons, active-high, asynchronous
// BEHAVIOUR
//  Bit order (both pads, shifted LSB first): 0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right.
//  Input path per button (16 total): 2-flop synchroniser -> debounce -> debounced state db[n].
//   Debounce: counter clears whenever sync value == db; otherwise increments each cycle; when count
//   reaches DEBOUNCE_CYCLES-1, db takes sync value and counter clears. Counter width
//   $clog2(DEBOUNCE_CYCLES+1). A pulse shorter than DEBOUNCE_CYCLES cycles never reaches db.
//  Opposing filter (combinational on db, BLOCK_OPPOSING=1): if Up&Down then both 0; if Left&Right
//   then both 0; other bits unaffected. BLOCK_OPPOSING=0: db passed through.
//  Shift register sr0/sr1 (8 bits each), independent per pad:
//   - strobe_i=1 at a clk edge: sr <= filtered db (every cycle while high; rd_i ignored).
//   - strobe_i=0 and rd_i[n]=1: srn <= {1'b1, srn[7:1]} (1s fill in from MSB).
//   - otherwise hold.
//  data_o[n] = srn[0], directly from the register (no extra pipeline stage).
//  Handshake timing: CPU samples data_o in the cycle it decodes the read; rd_i pulse arrives the
//   following cycle; shift takes effect on that edge, so next bit is visible one cycle after rd_i.
//  Boundaries:
//   - more than 8 reads without strobe: data_o[n]=1 for every further read (official-pad behaviour).
//   - strobe and rd_i same cycle: reload wins, no shift.
//   - strobe held high: data_o reflects current filtered A button, updated each cycle (1-cycle lag).
//   - rd_i[0] and rd_i[1] same cycle: both pads shift.
//   - strobe falling edge: last value loaded while high is retained; no load on the low cycle.
//  Reset: sr0=sr1=8'h00, data_o=2'b00, synchroniser flops=0, db=0, debounce counters=0.
//   Reset mid-sequence discards any partially shifted data; first post-reset reads return 0 until
//   the ninth read (then 1s) unless a strobe occurs.
// TESTING (bench uses DEBOUNCE_CYCLES=4)
//  1 Reset, no strobe, 10 rd_i[0] pulses -> data_o[0] = 0 x8 then 1,1; data_o[1] stays 0.
//  2 btn0_i=8'h09 held 10 cycles, strobe 1 then 0, 8 reads -> data_o[0] sequence 1,0,0,1,0,0,0,0.
//  3 btn0_i[0] high for 3 cycles then low, strobe/read -> A reads 0; held 6 cycles -> A reads 1.
//  4 strobe_i held 1, btn0_i[0] toggled (debounced) with rd_i[0] pulses -> data_o[0] tracks A, no shift.
//  5 btn1_i=8'h30 (Up+Down) + 8'h01, BLOCK_OPPOSING=1 -> pad1 sequence 1,0,0,0,0,0,0,0; =0 -> bits4,5 read 1.
//  6 strobe_i=1 with rd_i=2'b11 same cycle, btn0=8'h02 btn1=8'h01 -> reload, data_o=2'b10 after strobe low.

Source files
------------

// File: rtl/nes_joypad.sv
// ---------------------------------------------------------------------------
// nes_joypad
//
// Responder side of the NES controller serial port. It models two standard
// pads, each an 8-bit parallel-in/serial-out register in the style of the
// 4021, behind the $4016/$4017 strobe/read/data handshake.
//
// Input path, for each of the 16 raw buttons:
//   2-flop synchroniser -> debouncer -> opposing-direction filter
// The filtered value is latched into the pad shift register while strobe is
// high. Each read pulse then shifts it out LSB first, and 1s fill in from the
// MSB.
//
// Ports
//   clk       system clock
//   rst       synchronous reset, active-high
//   strobe_i  latch control; while high the pads reload on every cycle
//   rd_i      one-cycle read pulses; bit0 = pad 0 ($4016), bit1 = pad 1 ($4017)
//   data_o    serial data; bit n = bit 0 of the pad n shift register
//   btn0_i    pad 0 raw buttons, active-high, asynchronous
//   btn1_i    pad 1 raw buttons, active-high, asynchronous
//
// Button order within a pad: 0 A, 1 B, 2 Select, 3 Start,
//                            4 Up, 5 Down, 6 Left, 7 Right
// ---------------------------------------------------------------------------
module nes_joypad #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit BLOCK_OPPOSING  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       strobe_i,
  input  logic [1:0] rd_i,
  output logic [1:0] data_o,
  input  logic [7:0] btn0_i,
  input  logic [7:0] btn1_i
);

  localparam int NBTN  = 16;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam int BTN_UP    = 4;
  localparam int BTN_DOWN  = 5;
  localparam int BTN_LEFT  = 6;
  localparam int BTN_RIGHT = 7;

  // Up+Down or Left+Right pressed together cannot happen on a real pad.
  // Games can misbehave if they see it, so both buttons of the pair are
  // reported as released.
  function automatic logic [7:0] block_opposing(input logic [7:0] b);
    logic [7:0] f;
    f = b;
    if (b[BTN_UP] && b[BTN_DOWN]) begin
      f[BTN_UP]   = 1'b0;
      f[BTN_DOWN] = 1'b0;
    end
    if (b[BTN_LEFT] && b[BTN_RIGHT]) begin
      f[BTN_LEFT]  = 1'b0;
      f[BTN_RIGHT] = 1'b0;
    end
    return f;
  endfunction

  function automatic logic [7:0] pad_filter(input logic [7:0] b);
    return BLOCK_OPPOSING ? block_opposing(b) : b;
  endfunction

  logic [NBTN-1:0] raw;
  logic [NBTN-1:0] sync_p0;
  logic [NBTN-1:0] sync_p1;
  logic [NBTN-1:0] db;
  logic [7:0]      filt0;
  logic [7:0]      filt1;
  logic [7:0]      sr0;
  logic [7:0]      sr1;

  assign raw = {btn1_i, btn0_i};

  // ---- stage p0/p1: two-flop synchroniser for the asynchronous buttons ----
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // ---- debounce: one counter per button ----
  // The counter runs only while the synchronised value disagrees with the
  // accepted state. Because both are single bits, a run of disagreement
  // means the input held one steady value for that many cycles. Any cycle
  // of agreement restarts the count.
  for (genvar i = 0; i < NBTN; i++) begin : g_db
    logic             db_r;
    logic [CNT_W-1:0] cnt_r;

    always_ff @(posedge clk) begin
      if (rst) begin
        db_r  <= 1'b0;
        cnt_r <= '0;
      end else if (sync_p1[i] == db_r) begin
        cnt_r <= '0;
      end else if (cnt_r == CNT_LAST) begin
        db_r  <= sync_p1[i];
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end

    assign db[i] = db_r;
  end

  assign filt0 = pad_filter(db[7:0]);
  assign filt1 = pad_filter(db[15:8]);

  // ---- pad shift registers ----
  // Strobe has priority over read, so a read in the same cycle as a reload
  // is lost, just as on the real 4021. Shifting in 1s makes reads past the
  // eighth return 1, which matches official pads.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr0 <= 8'h00;
      sr1 <= 8'h00;
    end else if (strobe_i) begin
      sr0 <= filt0;
      sr1 <= filt1;
    end else begin
      if (rd_i[0]) sr0 <= {1'b1, sr0[7:1]};
      if (rd_i[1]) sr1 <= {1'b1, sr1[7:1]};
    end
  end

  // The CPU samples data_o in the cycle it decodes the read, so the output
  // comes straight from the register with no extra stage.
  assign data_o = {sr1[0], sr0[0]};

endmodule
